// File: rtl/cl_line_framer.sv
// cl_line_framer
// Pulls pixels from a first-word-fall-through FIFO and frames them as
// CameraLink-style FVAL/LVAL/DVAL strobes plus pixel data. A frame is
// V_ACTIVE lines of H_ACTIVE pixels, each line preceded by H_BLANK clocks of
// FVAL-only time and the frame followed by V_BLANK clocks of FVAL low.
// Starved LINE cycles stretch the line rather than shortening it, and are
// counted in a saturating underrun counter.
module cl_line_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 32,
  parameter int V_ACTIVE   = 480,
  parameter int V_BLANK    = 64
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  cl_fval,
  output logic                  cl_lval,
  output logic                  cl_dval,
  output logic [DATA_WIDTH-1:0] cl_data,
  output logic                  frame_done,
  output logic [15:0]           underrun_cnt
);

  // The blanking counter is shared by SETUP/HBLANK and VBLANK, so it must
  // hold the larger of the two blanking lengths.
  localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int HW        = $clog2(BLANK_MAX + 1);
  localparam int PW        = $clog2(H_ACTIVE + 1);
  localparam int LW        = $clog2(V_ACTIVE + 1);

  // Terminal counts, pre-sized so every compare is width-matched.
  localparam logic [HW-1:0] H_LAST = HW'(H_BLANK - 1);
  localparam logic [HW-1:0] V_LAST = HW'(V_BLANK - 1);
  localparam logic [PW-1:0] P_LAST = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(V_ACTIVE - 1);
  localparam logic [15:0]   U_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } state_t;

  state_t          state_reg;
  logic [HW-1:0]   hcnt_reg;
  logic [PW-1:0]   pcnt_reg;
  logic [LW-1:0]   lcnt_reg;

  logic            in_line;
  logic            in_fval;
  logic            starved;
  logic            last_pixel;
  logic            last_line;

  // Current-cycle decode shared by the pop strobe and the registered outputs.
  assign in_line    = (state_reg == LINE);
  assign in_fval    = (state_reg == SETUP) || (state_reg == LINE) ||
                      (state_reg == HBLANK);
  assign starved    = in_line && fifo_empty;
  assign last_pixel = (pcnt_reg == P_LAST);
  assign last_line  = (lcnt_reg == L_LAST);

  // Pop only in LINE with a word available; the reset term guarantees no pop
  // happens on the edge that resets the framer, whatever state it was in.
  assign fifo_rd_en = in_line && !fifo_empty && !rd_rst;

  // Frame sequencer: state, counters and the registered strobes.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_reg    <= IDLE;
      hcnt_reg     <= '0;
      pcnt_reg     <= '0;
      lcnt_reg     <= '0;
      cl_fval      <= 1'b0;
      cl_lval      <= 1'b0;
      cl_dval      <= 1'b0;
      frame_done   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      // Strobes follow the state with one cycle of lag, matching cl_data.
      cl_fval    <= in_fval;
      cl_lval    <= in_line;
      cl_dval    <= in_line && fifo_rd_en;
      frame_done <= 1'b0;

      // Starvation is tallied for diagnostics and never wraps.
      if (starved && (underrun_cnt != U_MAX)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end

      case (state_reg)
        IDLE: begin
          // en is only honoured here, so dropping it mid-frame is harmless.
          if (en && !fifo_empty) begin
            state_reg <= SETUP;
            hcnt_reg  <= '0;
            lcnt_reg  <= '0;
          end
        end

        SETUP, HBLANK: begin
          if (hcnt_reg == H_LAST) begin
            hcnt_reg  <= '0;
            state_reg <= LINE;
          end else begin
            hcnt_reg <= hcnt_reg + HW'(1);
          end
        end

        LINE: begin
          // The line only ends on its final pop; empty cycles just wait.
          if (fifo_rd_en) begin
            if (last_pixel) begin
              pcnt_reg <= '0;
              hcnt_reg <= '0;
              if (last_line) begin
                state_reg <= VBLANK;
              end else begin
                lcnt_reg  <= lcnt_reg + LW'(1);
                state_reg <= HBLANK;
              end
            end else begin
              pcnt_reg <= pcnt_reg + PW'(1);
            end
          end
        end

        VBLANK: begin
          if (hcnt_reg == V_LAST) begin
            hcnt_reg   <= '0;
            state_reg  <= IDLE;
            frame_done <= 1'b1;
          end else begin
            hcnt_reg <= hcnt_reg + HW'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          hcnt_reg  <= '0;
          pcnt_reg  <= '0;
          lcnt_reg  <= '0;
        end
      endcase
    end
  end

  // Pixel data register: captures the FIFO head on each pop, holds otherwise.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_bit
      // One capture flop per pixel bit, loaded on every pop.
      always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
          cl_data[gi] <= 1'b0;
        end else if (fifo_rd_en) begin
          cl_data[gi] <= fifo_data[gi];
        end
      end
    end
  endgenerate

endmodule
